// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial CLA adder: state codes, slice
// width and the idx counter width helper.
package cla_nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  // State codes kept as plain constants so older tooling can consume them.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Width of the nibble index: clog2(WIDTH/4), never below 1.
  function automatic int idx_w(input int width);
    int n;
    n = width / NIB_W;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead slice. Produces the nibble sum plus group
// generate/propagate; the caller forms the group carry-out from those.
module cla_nibble_serial_adder_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // Lookahead carries into each bit, then the group terms.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
    pg   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract that pushes one nibble per clock
// through a single shared CLA4 slice, LSB nibble first, with the
// inter-nibble carry held in a register.
module cla_nibble_serial_adder
  import cla_nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / NIB_W;
  localparam int IW = idx_w(WIDTH);

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             pg;
  logic             gg;
  logic             slice_co;
  logic             last;

  // Select the current nibble of each operand and form the slice carry-out.
  always_comb begin
    nib_a    = a_r[idx*NIB_W +: NIB_W];
    nib_b    = b_r[idx*NIB_W +: NIB_W];
    slice_co = gg | (pg & carry);
    last     = (idx == IW'(N-1));
  end

  cla_nibble_serial_adder_cla4 u_cla4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .pg (pg),
    .gg (gg)
  );

  // Status flags decode straight from state so an async reset clears them at once.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Sequencer: latch operands, walk nibbles, publish the result on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtract is A + ~B + 1; the forced carry replaces cin.
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc[idx*NIB_W +: NIB_W] <= nib_s;
          carry <= slice_co;
          idx   <= idx + IW'(1);
          if (last) begin
            sum   <= {nib_s, acc[WIDTH-NIB_W-1:0]};
            cout  <= slice_co;
            ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (nib_s[NIB_W-1] != a_r[WIDTH-1]);
            idx   <= '0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder (WIDTH=16).
module tb_cla_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] prev_sum = '0;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Reference: plain unsigned and signed arithmetic on the whole word.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mcin, input logic msub,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    longint ua, ub, full, sa, sb, sres;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (msub) begin
      full = ua + (65535 - ub) + 1;
      sres = sa - sb;
    end else begin
      full = ua + ub + (mcin ? 1 : 0);
      sres = sa + sb + (mcin ? 1 : 0);
    end
    es = W'(full);
    ec = (full >= 65536);
    eo = (sres > 32767) || (sres < -32768);
  endtask

  // One full operation from idle, checking cycle timing, held outputs and result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tcin, input logic tsub, input string nm);
    logic [W-1:0] es;
    logic ec, eo;
    model(ta, tb_, tcin, tsub, es, ec, eo);
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum) begin
        n_fail++;
        $display("FAIL %s run cyc%0d: busy=%b done=%b sum=%h, want busy=1 done=0 sum=%h",
                 nm, i, busy, done, sum, prev_sum);
      end
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== es || cout !== ec || ovf !== eo) begin
      n_fail++;
      $display("FAIL %s result: done=%b busy=%b sum=%h cout=%b ovf=%b, want done=1 busy=0 sum=%h cout=%b ovf=%b",
               nm, done, busy, sum, cout, ovf, es, ec, eo);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post: done=%b busy=%b, want 0 0", nm, done, busy);
    end
    prev_sum = es;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0;
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "add_5555");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_neg");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "add_cin");
    run_op(16'h1234, 16'h1234, 1'b0, 1'b1, "sub_zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] es;
    logic ec, eo;
    int dones;
    model(16'h0F0F, 16'h00F1, 1'b0, 1'b0, es, ec, eo);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    n_chk++;
    if (dones != 1 || sum !== es || cout !== ec || ovf !== eo) begin
      n_fail++;
      $display("FAIL start_ignored: dones=%0d sum=%h cout=%b ovf=%b, want dones=1 sum=%h cout=%b ovf=%b",
               dones, sum, cout, ovf, es, ec, eo);
    end
    prev_sum = es;
  endtask

  task automatic test_abort();
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s1, s2;
    logic c1, c2, o1, o2;
    model(16'h8001, 16'h8001, 1'b0, 1'b0, s1, c1, o1);
    model(16'h0100, 16'h0FFF, 1'b0, 1'b1, s2, c2, o2);
    @(negedge clk);
    a = 16'h8001; b = 16'h8001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0100; b = 16'h0FFF; sub = 1'b1;
    for (int i = 1; i < N; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || sum !== s1 || cout !== c1 || ovf !== o1) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b sum=%h cout=%b ovf=%b, want done=1 sum=%h cout=%b ovf=%b",
               done, sum, cout, ovf, s1, c1, o1);
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0 || sum !== s1) begin
        n_fail++;
        $display("FAIL b2b_hold cyc%0d: busy=%b done=%b sum=%h, want busy=1 done=0 sum=%h",
                 i, busy, done, sum, s1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (done !== 1'b1 || sum !== s2 || cout !== c2 || ovf !== o2) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b sum=%h cout=%b ovf=%b, want done=1 sum=%h cout=%b ovf=%b",
               done, sum, cout, ovf, s2, c2, o2);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: done=%b busy=%b, want 0 0", done, busy);
    end
    prev_sum = s2;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_nibble_serial_adder.md
# cla_nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that time-shares one 4-bit carry-lookahead slice. It sequences operands through the slice one nibble per clock, least-significant nibble first, and carries the ripple between nibbles in a register. It sits beside the CLA datapath as its sequencing controller and is used wherever a full-width combinational adder is too large. Handshake: start/busy/done.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 8
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in; sampled with start; ignored when sub=1
- sub  input  1  1 = A − B (two's complement); sampled with start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result; held until the next result
- cout  output  1  carry out of bit WIDTH−1
- ovf  output  1  signed overflow

## Operation
- N = WIDTH/4 nibbles.
- Idx counter width: clog2(N), minimum 1.
- States:
  - IDLE
  - RUN
  - DONE
- Reset (async, any state):
  - state=IDLE, idx=0, carry=0
  - internal regs = 0
  - busy=0, done=0, sum=0, cout=0, ovf=0
- IDLE or DONE, start=1:
  - latch a_r = a
  - latch b_r = sub ? ~b : b
  - carry = sub ? 1 : cin
  - idx = 0, go to RUN
- RUN, each cycle:
  - slice inputs are a_r[4·idx+3:4·idx], b_r[same nibble] and carry.
  - Write the slice sum into acc[same nibble].
  - carry <= GG | (PG & carry).
  - idx <= idx+1.
- RUN, when idx == N−1:
  - also load outputs: sum <= {slice sum, acc lower bits}
  - cout <= slice carry out
  - ovf <= (a_r[MSB] == b_r[MSB]) & (new sum MSB != a_r[MSB])
  - go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Next state is RUN if start=1, else IDLE.
- start while in RUN is ignored. It is not queued.
- sum/cout/ovf change only on the RUN→DONE edge. Partial results are never visible on the outputs.
- Subtract result semantics: cout=1 means no borrow.

## Timing
- Let edge k sample start=1 in IDLE or DONE.
- busy is high in cycles k+1 … k+N. busy=0 in DONE.
- Nibble i is written at edge k+1+i.
- The outputs update at edge k+N.
- done is high in the cycle after edge k+N. Start-to-done latency is N+1 edges (5 for WIDTH=16).
- Back-to-back throughput: one result per N+1 cycles when start is held high.
- Reset mid-RUN aborts the operation: no done, outputs return to 0.

## Structure
- Shared package contents:
  - state enum {IDLE, RUN, DONE}
  - NIB_W=4
  - function for the idx width (clog2 of WIDTH/4, floor 1)
- One sub-module: the team's 4-bit CLA slice (CLA4), instantiated once.
  - Generate/propagate outputs feed the carry register.
  - carry-out = GG | (PG & Ci), computed in this block.
- The nibble mux and acc write use an indexed part-select on idx. No per-nibble adders.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0; done exactly 5 edges after start; busy high for 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Carry rippled through all 4 nibbles. Also check a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- start pulsed at RUN cycle 2 with different operands -> ignored. First result is unchanged and only one done pulse occurs.
- rst asserted asynchronously mid-RUN -> busy, done, sum, cout and ovf are 0 immediately. A later start completes correctly with no residue from the aborted carry.
- start held high across two operations -> second RUN begins directly from DONE. done pulses are 5 cycles apart, and sum holds result 1 until the second RUN→DONE edge.
